// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment constants (active-low glyphs, blank code) and slot timing helper
package ssd_pkg;
    localparam int MAX_DIGITS = 16;
    localparam logic [6:0] SSD_OFF = 7'h7F;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int slot_cycles(input int refresh_ns, input int clock_ns);
        return refresh_ns / clock_ns;
    endfunction
endpackage

// File: rtl/ssd_encode.sv
// ssd_encode: hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
module ssd_encode
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = GLYPH[hex];
endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: N-digit multiplexed seven-segment driver with dp, leading-zero blanking,
// PWM brightness, anti-ghost blank gap and frame-synchronous shadow loading
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLOCK_PERIOD   = 10,
    parameter int REFRESH_PERIOD = 655360,
    parameter int BLANK_CYCLES   = 64,
    parameter int BRIGHT_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*DIGITS-1:0]       digits,
    input  logic [DIGITS-1:0]         dp,
    input  logic [DIGITS-1:0]         mode,
    input  logic                      lz_suppress,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic [DIGITS-1:0]         an,
    output logic [$clog2(DIGITS)-1:0] scan_idx,
    output logic                      frame_done
);
    localparam int SLOT = slot_cycles(REFRESH_PERIOD, CLOCK_PERIOD);
    localparam int SW   = $clog2(SLOT);
    localparam int IW   = $clog2(DIGITS);

    if (DIGITS < 2 || DIGITS > MAX_DIGITS || BLANK_CYCLES >= SLOT - 1) begin : g_bad_params
        $error("ssd_scan_controller: DIGITS must be 2..16 and BLANK_CYCLES < SLOT-1");
    end

    logic [SW-1:0]       slot_cnt;
    logic [IW-1:0]       idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [4*DIGITS-1:0] pend_dig, act_dig;
    logic [DIGITS-1:0]   pend_dp, act_dp, pend_mode, act_mode;
    logic                pend_v;
    logic [DIGITS-1:0]   lz_blank;
    logic [3:0]          nib;
    logic [6:0]          glyph;
    logic                wrap, last, boundary, lit;

    assign wrap     = slot_cnt == SW'(SLOT - 1);
    assign last     = idx == IW'(DIGITS - 1);
    assign boundary = en && wrap && last;
    assign lit      = en && slot_cnt >= SW'(BLANK_CYCLES) && pwm_cnt <= brightness && act_mode[idx];
    assign nib      = act_dig[{idx, 2'b00} +: 4];

    // Walk from the most significant digit down; a digit is blanked while nothing above or at it is non-zero.
    always_comb begin
        logic acc;
        acc = 1'b0;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc = acc | (|act_dig[4*i +: 4]);
            lz_blank[i] = lz_suppress & ~acc & (i != 0);
        end
    end

    ssd_encode u_encode (
        .hex (nib),
        .seg (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_cnt   <= '0;
            idx        <= '0;
            pwm_cnt    <= '0;
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_mode  <= '0;
            pend_v     <= 1'b0;
            act_dig    <= '0;
            act_dp     <= '0;
            act_mode   <= '0;
            an         <= '1;
            seg        <= SSD_OFF;
            dp_n       <= 1'b1;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (en) begin
                pwm_cnt  <= pwm_cnt + BRIGHT_W'(1);
                slot_cnt <= wrap ? '0 : slot_cnt + SW'(1);
                if (wrap)
                    idx <= last ? '0 : idx + IW'(1);
            end
            // A load landing on the boundary bypasses pending so it is never held back a whole frame.
            if (boundary) begin
                act_dig  <= load ? digits : pend_v ? pend_dig : act_dig;
                act_dp   <= load ? dp : pend_v ? pend_dp : act_dp;
                act_mode <= load ? mode : pend_v ? pend_mode : act_mode;
                pend_v   <= 1'b0;
            end else if (load) begin
                pend_dig  <= digits;
                pend_dp   <= dp;
                pend_mode <= mode;
                pend_v    <= 1'b1;
            end
            an         <= lit ? ~(DIGITS'(1) << idx) : '1;
            seg        <= (lit && !lz_blank[idx]) ? glyph : SSD_OFF;
            dp_n       <= !(lit && act_dp[idx]);
            scan_idx   <= idx;
            frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_ssd_scan_controller.sv
// tb_ssd_scan_controller: directed bench for the scan controller (DIGITS=4, SLOT=10, BLANK=2, BRIGHT_W=2)
module tb_ssd_scan_controller;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, load = 1'b0, lz = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0, mode = '0;
    logic [1:0]  br = '0;
    logic [6:0]  seg;
    logic        dp_n, frame_done;
    logic [3:0]  an;
    logic [1:0]  scan_idx;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .DIGITS(4), .CLOCK_PERIOD(10), .REFRESH_PERIOD(100), .BLANK_CYCLES(2), .BRIGHT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .digits(digits), .dp(dp), .mode(mode),
        .lz_suppress(lz), .brightness(br), .seg(seg), .dp_n(dp_n), .an(an),
        .scan_idx(scan_idx), .frame_done(frame_done)
    );

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
            4'h4: return 7'b0011001; 4'h5: return 7'b0010010; 4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
            4'h8: return 7'b0000000; 4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
            4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110; default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag, input logic [1:0] e_idx);
        chk({tag, "_an"}, an, 4'hF);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dp"}, dp_n, 1'b1);
        chk({tag, "_idx"}, scan_idx, e_idx);
        chk({tag, "_fd"}, frame_done, 1'b0);
    endtask

    // Samples frame positions from..to; position j = slot j%10 of digit j/10, pwm phase j%4.
    task automatic span(input string tag, input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] mv,
                        input int from, input int to);
        for (int j = from; j <= to; j++) begin
            int i;
            logic lit, blank;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            @(negedge clk);
            i = j / 10;
            lit = (j % 10 >= 2) && ((j % 4) <= int'(br)) && mv[i];
            blank = lz && (i != 0) && ((d >> (4 * i)) == 16'h0);
            e_an = lit ? ~(4'b0001 << i) : 4'hF;
            e_seg = (lit && !blank) ? hex_glyph(d[4*i +: 4]) : 7'h7F;
            chk($sformatf("%s_an@%0d", tag, j), an, e_an);
            chk($sformatf("%s_seg@%0d", tag, j), seg, e_seg);
            chk($sformatf("%s_dp@%0d", tag, j), dp_n, !(lit && dpv[i]));
            chk($sformatf("%s_idx@%0d", tag, j), scan_idx, i);
            chk($sformatf("%s_fd@%0d", tag, j), frame_done, j == 39);
        end
    endtask

    task automatic wait_frame(input string tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        chk({tag, "_frame_wait"}, frame_done, 1'b1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] mv);
        digits = d; dp = dpv; mode = mv; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_dark("reset", 2'd0);
        rst = 1'b1; en = 1'b1; br = 2'd3;
        do_load(16'h1234, 4'h0, 4'hF);
        wait_frame("basic");
        span("basic", 16'h1234, 4'h0, 4'hF, 0, 39);
        span("basic2", 16'h1234, 4'h0, 4'hF, 0, 39);
        br = 2'd0;
        span("bright0", 16'h1234, 4'h0, 4'hF, 0, 39);
        br = 2'd1;
        span("bright1", 16'h1234, 4'h0, 4'hF, 0, 39);
        br = 2'd3; lz = 1'b1;
        do_load(16'h0030, 4'h0, 4'hF);
        wait_frame("lz30");
        span("lz30", 16'h0030, 4'h0, 4'hF, 0, 39);
        do_load(16'h0000, 4'h0, 4'hF);
        wait_frame("lz00");
        span("lz00", 16'h0000, 4'h0, 4'hF, 0, 39);
        span("tear_old", 16'h0000, 4'h0, 4'hF, 0, 14);
        digits = 16'hABCD; load = 1'b1;
        span("tear_old", 16'h0000, 4'h0, 4'hF, 15, 15);
        load = 1'b0;
        span("tear_old", 16'h0000, 4'h0, 4'hF, 16, 39);
        span("tear_new", 16'hABCD, 4'h0, 4'hF, 0, 38);
        digits = 16'h5678; load = 1'b1;
        span("tear_edge", 16'hABCD, 4'h0, 4'hF, 39, 39);
        load = 1'b0; digits = 16'h9999;
        span("edge_new", 16'h5678, 4'h0, 4'hF, 0, 39);
        span("edge_hold", 16'h5678, 4'h0, 4'hF, 0, 39);
        lz = 1'b0;
        do_load(16'h1234, 4'b0101, 4'b1011);
        wait_frame("dpmode");
        span("dpmode", 16'h1234, 4'b0101, 4'b1011, 0, 39);
        span("en_pre", 16'h1234, 4'b0101, 4'b1011, 0, 14);
        en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk_dark("en_off", 2'd1);
        end
        en = 1'b1;
        span("en_resume", 16'h1234, 4'b0101, 4'b1011, 15, 39);
        span("rst_pre", 16'h1234, 4'b0101, 4'b1011, 0, 9);
        digits = 16'h8888; mode = 4'hF; load = 1'b1;
        span("rst_pre", 16'h1234, 4'b0101, 4'b1011, 10, 10);
        load = 1'b0;
        span("rst_pre", 16'h1234, 4'b0101, 4'b1011, 11, 19);
        rst = 1'b0;
        @(negedge clk);
        chk_dark("midrst", 2'd0);
        rst = 1'b1;
        span("post_rst", 16'h0000, 4'h0, 4'h0, 0, 39);
        span("post_rst2", 16'h0000, 4'h0, 4'h0, 0, 39);
        do_load(16'h4321, 4'h0, 4'hF);
        wait_frame("reload");
        span("reload", 16'h4321, 4'h0, 4'hF, 0, 39);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "simulation time limit reached");
    end
endmodule
